// File: rtl/frame_byte_scheduler_pkg.sv
// Shared types, tag constants and helpers for the framed-word byte scheduler.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [5:0] TAG3 = 6'b011000;
  localparam logic [2:0] TAG2 = 3'b010;
  localparam logic [2:0] TAG1 = 3'b001;
  localparam logic [2:0] TAG0 = 3'b000;

  localparam int         BYTES_PER_FRAME = 4;
  localparam logic [1:0] IDX_FIRST       = 2'(BYTES_PER_FRAME - 1);
  localparam logic [7:0] DROP_MAX        = 8'hFF;

  function automatic logic tags_ok(input logic [31:0] word);
    return (word[31:26] == TAG3) && (word[23:21] == TAG2) &&
           (word[15:13] == TAG1) && (word[7:5] == TAG0);
  endfunction

  // Index 3 is the MSB byte, which goes out first.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd3:    b = word[31:24];
      2'd2:    b = word[23:16];
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_byte_scheduler_tick_divider.sv
// Sample prescaler: one-cycle tick every DIV enabled cycles, held at 0 while disabled.
module tick_divider #(
  parameter int DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/frame_byte_scheduler.sv
// Samples the framed counter word on prescaler ticks, checks its tags and
// paces its four bytes, MSB first, onto a valid/ready byte link.
//
//   state | meaning
//   IDLE  | waiting for a tick; captures and tag-checks word_in
//   SEND  | byte_valid=1, holding byte idx until the sink takes it
//   GAP   | byte_valid=0 for GAP_CYCLES cycles between bytes of a frame
module frame_byte_scheduler
  import frame_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int GAP_CYCLES = 4,
  parameter bit CHECK_TAGS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] word_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        tag_err,
  output logic [7:0]  drop_cnt
);

  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state;
  logic [31:0]   shadow;
  logic [1:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic          tick;
  logic          xfer;

  tick_divider #(.DIV(SAMPLE_DIV)) u_div (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign xfer = byte_valid && byte_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shadow     <= '0;
      idx        <= IDX_FIRST;
      gap_cnt    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      tag_err    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      // A tick on the final-byte transfer cycle still counts as a drop.
      if (tick && (state != IDLE) && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            shadow <= word_in;
            if (!CHECK_TAGS || tags_ok(word_in)) begin
              state      <= SEND;
              idx        <= IDX_FIRST;
              byte_out   <= byte_sel(word_in, IDX_FIRST);
              byte_valid <= 1'b1;
            end else begin
              tag_err <= 1'b1;
            end
          end
        end

        SEND: begin
          if (xfer) begin
            if (idx == 2'd0) begin
              state      <= IDLE;
              byte_valid <= 1'b0;
            end else begin
              idx <= idx - 2'd1;
              if (GAP_CYCLES == 0) begin
                byte_out <= byte_sel(shadow, idx - 2'd1);
              end else begin
                state      <= GAP;
                byte_valid <= 1'b0;
                gap_cnt    <= GAP_LAST;
              end
            end
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state      <= SEND;
            byte_valid <= 1'b1;
            byte_out   <= byte_sel(shadow, idx);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        default: begin
          state      <= IDLE;
          byte_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_byte_scheduler.sv
// Scoreboard bench: three scheduler instances (no-gap, 4-cycle gap, fast stalled sink).
module tb_frame_byte_scheduler;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: SAMPLE_DIV=8, GAP_CYCLES=0
  logic        a_reset, a_enable, a_ready, a_valid, a_busy, a_tag_err;
  logic [31:0] a_word;
  logic [7:0]  a_byte, a_drop;
  // Instance B: SAMPLE_DIV=8, GAP_CYCLES=4
  logic        b_reset, b_enable, b_ready, b_valid, b_busy, b_tag_err;
  logic [31:0] b_word;
  logic [7:0]  b_byte, b_drop;
  // Instance C: SAMPLE_DIV=2, GAP_CYCLES=0, sink never ready
  logic        c_reset, c_enable, c_ready, c_valid, c_busy, c_tag_err;
  logic [31:0] c_word;
  logic [7:0]  c_byte, c_drop;

  frame_byte_scheduler #(.SAMPLE_DIV(8), .GAP_CYCLES(0), .CHECK_TAGS(1'b1)) dut_a (
    .clock(clock), .reset(a_reset), .enable(a_enable), .word_in(a_word),
    .byte_out(a_byte), .byte_valid(a_valid), .byte_ready(a_ready),
    .busy(a_busy), .tag_err(a_tag_err), .drop_cnt(a_drop)
  );

  frame_byte_scheduler #(.SAMPLE_DIV(8), .GAP_CYCLES(4), .CHECK_TAGS(1'b1)) dut_b (
    .clock(clock), .reset(b_reset), .enable(b_enable), .word_in(b_word),
    .byte_out(b_byte), .byte_valid(b_valid), .byte_ready(b_ready),
    .busy(b_busy), .tag_err(b_tag_err), .drop_cnt(b_drop)
  );

  frame_byte_scheduler #(.SAMPLE_DIV(2), .GAP_CYCLES(0), .CHECK_TAGS(1'b1)) dut_c (
    .clock(clock), .reset(c_reset), .enable(c_enable), .word_in(c_word),
    .byte_out(c_byte), .byte_valid(c_valid), .byte_ready(c_ready),
    .busy(c_busy), .tag_err(c_tag_err), .drop_cnt(c_drop)
  );

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input bit to_b, input int t3, input int t2, input int t1, input int t0);
    exp_t e;
    e.data = 8'h60; e.cyc = t3; if (to_b) q_b.push_back(e); else q_a.push_back(e);
    e.data = 8'h48; e.cyc = t2; if (to_b) q_b.push_back(e); else q_a.push_back(e);
    e.data = 8'h22; e.cyc = t1; if (to_b) q_b.push_back(e); else q_a.push_back(e);
    e.data = 8'h00; e.cyc = t0; if (to_b) q_b.push_back(e); else q_a.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor A: transfers against the scoreboard, plus hold-while-stalled.
  logic       a_rst_seen = 1'b1;
  logic       a_stall    = 1'b0;
  logic [7:0] a_hold     = 8'h00;
  always @(posedge clock) a_rst_seen <= a_reset;

  always @(negedge clock) begin
    exp_t e;
    if (a_rst_seen) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall) begin
        check("a_hold_valid", 32'(a_valid), 32'd1);
        check("a_hold_byte", 32'(a_byte), 32'(a_hold));
      end
      if (a_valid && a_ready) begin
        if (q_a.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL a_unexpected_byte: got %0h, expected no transfer (cycle %0d)", a_byte, cyc);
        end else begin
          e = q_a.pop_front();
          check("a_byte", 32'(a_byte), 32'(e.data));
          check("a_byte_cycle", cyc, e.cyc);
        end
      end
      a_stall = a_valid && !a_ready;
      a_hold  = a_byte;
    end
  end

  // Monitor B: transfer values and cycles (gap spacing) against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!b_reset && b_valid && b_ready) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_byte: got %0h, expected no transfer (cycle %0d)", b_byte, cyc);
      end else begin
        e = q_b.pop_front();
        check("b_byte", 32'(b_byte), 32'(e.data));
        check("b_byte_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int c0;
    int exp_drop;
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_enable = 1'b0; b_enable = 1'b0; c_enable = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b0;
    a_word = 32'h6048_2200; b_word = 32'h6048_2200; c_word = 32'h6048_2200;
    step(2);

    check("rst_byte_out", 32'(a_byte), 32'h0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_tag_err", 32'(a_tag_err), 32'd0);
    check("rst_drop_cnt", 32'(a_drop), 32'd0);
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    step(2);

    // Back-to-back frame, first byte one cycle after the tick.
    c0 = cyc;
    a_enable = 1'b1;
    push_frame(1'b0, c0 + 8, c0 + 9, c0 + 10, c0 + 11);
    step(8);
    check("t1_busy", 32'(a_busy), 32'd1);
    a_enable = 1'b0;
    step(8);
    check("t1_idle", 32'(a_busy), 32'd0);

    // Sink stalls 5 cycles on byte 2; enable drops mid-frame.
    c0 = cyc;
    a_enable = 1'b1;
    push_frame(1'b0, c0 + 8, c0 + 14, c0 + 15, c0 + 16);
    step(9);
    a_ready = 1'b0;
    a_enable = 1'b0;
    step(5);
    a_ready = 1'b1;
    step(8);

    // Bad TAG3: rejected, sticky error.
    a_word = 32'hE048_2200;
    c0 = cyc;
    a_enable = 1'b1;
    step(8);
    check("t4_tag_err", 32'(a_tag_err), 32'd1);
    check("t4_busy", 32'(a_busy), 32'd0);
    check("t4_valid", 32'(a_valid), 32'd0);
    a_enable = 1'b0;
    // Bad TAG0 is rejected as well.
    a_word = 32'h6048_2220;
    step(2);
    a_enable = 1'b1;
    step(8);
    check("t4_tag0_busy", 32'(a_busy), 32'd0);
    check("t4_tag0_valid", 32'(a_valid), 32'd0);
    a_enable = 1'b0;
    // A good word afterwards still goes out; error stays set.
    a_word = 32'h6048_2200;
    step(2);
    c0 = cyc;
    a_enable = 1'b1;
    push_frame(1'b0, c0 + 8, c0 + 9, c0 + 10, c0 + 11);
    step(8);
    a_enable = 1'b0;
    step(8);
    check("t4_tag_err_sticky", 32'(a_tag_err), 32'd1);

    // Reset while byte 2 is pending, after one drop.
    c0 = cyc;
    a_enable = 1'b1;
    q_a.push_back('{data: 8'h60, cyc: c0 + 8});
    step(9);
    a_ready = 1'b0;
    step(7);
    check("t6_drop_before", 32'(a_drop), 32'd1);
    check("t6_valid_before", 32'(a_valid), 32'd1);
    check("t6_byte_before", 32'(a_byte), 32'h48);
    a_reset = 1'b1;
    step(1);
    a_reset = 1'b0;
    check("t6_valid_after", 32'(a_valid), 32'd0);
    check("t6_busy_after", 32'(a_busy), 32'd0);
    check("t6_drop_after", 32'(a_drop), 32'd0);
    check("t6_tag_err_after", 32'(a_tag_err), 32'd0);
    check("t6_byte_after", 32'(a_byte), 32'h0);
    a_ready = 1'b1;
    push_frame(1'b0, c0 + 25, c0 + 26, c0 + 27, c0 + 28);
    step(8);
    a_enable = 1'b0;
    step(8);

    // Four idle cycles between bytes; frame spans 16 cycles.
    c0 = cyc;
    b_enable = 1'b1;
    push_frame(1'b1, c0 + 8, c0 + 13, c0 + 18, c0 + 23);
    step(8);
    b_enable = 1'b0;
    step(20);

    // Permanently stalled sink at SAMPLE_DIV=2: drops count up and saturate.
    c0 = cyc;
    c_enable = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      step(1);
      exp_drop = (i >= 2) ? (i - 2) / 2 : 0;
      if (exp_drop > 255) exp_drop = 255;
      check("t5_drop_cnt", 32'(c_drop), exp_drop);
    end
    check("t5_valid", 32'(c_valid), 32'd1);
    check("t5_byte", 32'(c_byte), 32'h60);
    check("t5_busy", 32'(c_busy), 32'd1);

    check("a_queue_left", q_a.size(), 32'd0);
    check("b_queue_left", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
